id_pipe_stage: RTL and testbench

ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

---
 rtl/id_pipe_stage.sv | 192 +++++++++++++++++++
 tb/tb_id_pipe_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: instruction decode stage with register file, write-back bypass,
// load-use hazard detection, early beq/bne resolution and flush on redirect.
// Optional build macro ID_STALL_CNT_EN enables a saturating load-use stall counter;
// without it stall_cnt is tied to zero.
module id_pipe_stage #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int RIDX  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            ex_valid,
  input  logic            ex_memread,
  input  logic [RIDX-1:0] ex_rd,
  input  logic            wb_we,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            redirect,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [RIDX-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic [15:0]     stall_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [RIDX-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0]   regs [NREGS];
  logic [XLEN-1:0]   rs1_val, rs2_val, imm_x;
  logic signed [31:0] imm32;
  logic              dec_reg_write, dec_mem_read, dec_mem_write, dec_br_taken;
  logic              hazard, xfer;

  assign opcode  = in_inst[6:0];
  assign funct3  = in_inst[14:12];
  assign rd_idx  = in_inst[7 +: RIDX];
  assign rs1_idx = in_inst[15 +: RIDX];
  assign rs2_idx = in_inst[20 +: RIDX];

  assign hazard   = in_valid & ex_valid & ex_memread & (ex_rd != '0) &
                    ((ex_rd == rs1_idx) | (ex_rd == rs2_idx));
  assign in_ready = !hazard & (!out_valid | out_ready) & !redirect;
  assign xfer     = in_valid & in_ready;

  // Register file; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Operand read with same-cycle write-back forwarding.
  always_comb begin
    rs1_val = regs[rs1_idx];
    rs2_val = regs[rs2_idx];
    if (wb_we && wb_rd != '0 && wb_rd == rs1_idx) rs1_val = wb_data;
    if (wb_we && wb_rd != '0 && wb_rd == rs2_idx) rs2_val = wb_data;
    if (rs1_idx == '0) rs1_val = '0;
    if (rs2_idx == '0) rs2_val = '0;
  end

  // Immediate extraction per format and control decode from opcode.
  always_comb begin
    imm32         = '0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    case (opcode)
      OP_IMM, OP_JALR: begin
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_reg_write = 1'b1;
      end
      OP_LOAD: begin
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      OP_STORE: begin
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm32 = {in_inst[31:12], 12'b0};
        dec_reg_write = 1'b1;
      end
      OP_JAL: begin
        imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        dec_reg_write = 1'b1;
      end
      OP_REG: dec_reg_write = 1'b1;
      default: ;
    endcase
  end

  assign imm_x = XLEN'(imm32);

  // Only beq (funct3 000) and bne (funct3 001) are resolved here.
  assign dec_br_taken = (opcode == OP_BRANCH) &&
                        (((funct3 == 3'b000) && (rs1_val == rs2_val)) ||
                         ((funct3 == 3'b001) && (rs1_val != rs2_val)));

  // Output pipeline register: redirect flush, then load, bubble, drain or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      br_taken      <= 1'b0;
      br_target     <= '0;
    end else if (redirect) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      br_taken      <= 1'b0;
    end else if (xfer) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1       <= rs1_val;
      out_rs2       <= rs2_val;
      out_imm       <= imm_x;
      out_rd        <= rd_idx;
      out_reg_write <= dec_reg_write;
      out_mem_read  <= dec_mem_read;
      out_mem_write <= dec_mem_write;
      br_taken      <= dec_br_taken;
      br_target     <= in_pc + imm_x;
    end else begin
      br_taken <= 1'b0;
      if (!out_valid || out_ready) begin
        out_valid <= 1'b0;
        if (hazard) begin
          out_reg_write <= 1'b0;
          out_mem_read  <= 1'b0;
          out_mem_write <= 1'b0;
        end
      end
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of load-use hazard cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (hazard && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: stimulus pushes hand-computed expected
// decode results into a queue; a monitor pops and compares on each handshake.
module tb_id_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        ex_valid, ex_memread;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1, out_rs2, out_imm;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        br_taken;
  logic [31:0] br_target;
  logic [15:0] stall_cnt;

  id_pipe_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect(redirect),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .br_taken(br_taken), .br_target(br_target),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        rw, mr, mw, br;
    logic [31:0] bt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef ID_STALL_CNT_EN
  localparam logic [15:0] STALL_ONE = 16'd1;
  localparam logic [15:0] STALL_TWO = 16'd2;
`else
  localparam logic [15:0] STALL_ONE = 16'd0;
  localparam logic [15:0] STALL_TWO = 16'd0;
`endif

  function automatic exp_t mk(logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] imm, logic [4:0] rd, logic rw, logic mr,
                              logic mw, logic br, logic [31:0] bt);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.bt = bt;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Present one instruction; expect it to be accepted this cycle.
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input exp_t e,
                       input string nm);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
    @(negedge clk);
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    #1;
    if (in_ready) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every accepted output against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected output", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_pc", 64'(out_pc), 64'(e.pc));
        chk("out_rs1", 64'(out_rs1), 64'(e.rs1));
        chk("out_rs2", 64'(out_rs2), 64'(e.rs2));
        chk("out_imm", 64'(out_imm), 64'(e.imm));
        chk("out_rd", 64'(out_rd), 64'(e.rd));
        chk("out_reg_write", 64'(out_reg_write), 64'(e.rw));
        chk("out_mem_read", 64'(out_mem_read), 64'(e.mr));
        chk("out_mem_write", 64'(out_mem_write), 64'(e.mw));
        chk("br_taken", 64'(br_taken), 64'(e.br));
        if (e.br) chk("br_target", 64'(br_target), 64'(e.bt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 0; in_pc = 0; in_inst = 0;
    ex_valid = 0; ex_memread = 0; ex_rd = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0; redirect = 0; out_ready = 0;

    #12;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset br_taken", 64'(br_taken), 64'd0);
    chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset out_pc", 64'(out_pc), 64'd0);
    chk("reset out_reg_write", 64'(out_reg_write), 64'd0);
    chk("reset br_target", 64'(br_target), 64'd0);
    idle();
    rst = 1'b1;
    out_ready = 1'b1;

    // addi x5, x0, 12
    issue(32'h100, 32'h00C00293, mk(32'h100, 0, 0, 12, 5, 1, 0, 0, 0, 0), "addi x5");
    @(negedge clk);
    chk("latency out_valid", 64'(out_valid), 64'd1);
    chk("addi out_rd", 64'(out_rd), 64'd5);
    @(posedge clk); #1;

    // preload x3 = 0x33, x7 = 0xDEAD, attempt x0 = 0x1234
    wb_we = 1; wb_rd = 3; wb_data = 32'h33;   idle();
    wb_rd = 7; wb_data = 32'hDEAD;            idle();
    wb_rd = 0; wb_data = 32'h1234;            idle();
    wb_we = 0;

    // load-use: add x9, x3, x7 with load to x3 in EX
    ex_valid = 1; ex_memread = 1; ex_rd = 3;
    in_valid = 1; in_pc = 32'h200; in_inst = 32'h007184B3;
    @(negedge clk);
    chk("hazard in_ready", 64'(in_ready), 64'd0);
    chk("stall_cnt before", 64'(stall_cnt), 64'd0);
    idle();
    chk("bubble out_valid", 64'(out_valid), 64'd0);
    chk("bubble reg_write", 64'(out_reg_write), 64'd0);
    chk("stall_cnt after hazard", 64'(stall_cnt), 64'(STALL_ONE));
    ex_valid = 0;
    issue(32'h200, 32'h007184B3, mk(32'h200, 32'h33, 32'hDEAD, 0, 9, 1, 0, 0, 0, 0), "add x9");

    // load to x0 in EX is not a hazard; x0 read ignores same-cycle write
    ex_valid = 1; ex_memread = 1; ex_rd = 0;
    wb_we = 1; wb_rd = 0; wb_data = 32'h1234;
    issue(32'h210, 32'h00000713, mk(32'h210, 0, 0, 0, 14, 1, 0, 0, 0, 0), "addi x14 x0");
    ex_valid = 0; ex_memread = 0;

    // same-cycle write-back forwarding, then the stored value
    wb_we = 1; wb_rd = 11; wb_data = 32'hABCD;
    issue(32'h220, 32'h00058533, mk(32'h220, 32'hABCD, 0, 0, 10, 1, 0, 0, 0, 0), "bypass x11");
    wb_we = 0;
    issue(32'h224, 32'h00058533, mk(32'h224, 32'hABCD, 0, 0, 10, 1, 0, 0, 0, 0), "stored x11");

    // sw x7,4(x3); lw x12,-4(x3); lui x13,0x12345
    issue(32'h230, 32'h0071A223, mk(32'h230, 32'h33, 32'hDEAD, 4, 4, 0, 0, 1, 0, 0), "sw");
    issue(32'h234, 32'hFFC1A603, mk(32'h234, 32'h33, 0, 32'hFFFFFFFC, 12, 1, 1, 0, 0, 0), "lw");
    issue(32'h238, 32'h123456B7, mk(32'h238, 0, 32'h33, 32'h12345000, 13, 1, 0, 0, 0, 0), "lui");

    // beq x7,x7,+8 at 0x40 with x7 also being written this cycle
    wb_we = 1; wb_rd = 7; wb_data = 32'hDEAD;
    issue(32'h40, 32'h00738463, mk(32'h40, 32'hDEAD, 32'hDEAD, 8, 8, 0, 0, 0, 1, 32'h48), "beq taken");
    wb_we = 0;
    issue(32'h50, 32'h00739463, mk(32'h50, 32'hDEAD, 32'hDEAD, 8, 8, 0, 0, 0, 0, 0), "bne not taken");
    issue(32'hFFFFFFFC, 32'h00039463,
          mk(32'hFFFFFFFC, 32'hDEAD, 0, 8, 8, 0, 0, 0, 1, 32'h4), "bne taken wrap");
    idle();
    chk("br_taken one cycle", 64'(br_taken), 64'd0);

    // backpressure: hold 0x300 for three cycles while 0x304 waits
    issue(32'h300, 32'h00100313, mk(32'h300, 0, 0, 1, 6, 1, 0, 0, 0, 0), "addi x6");
    out_ready = 0;
    in_valid = 1; in_pc = 32'h304; in_inst = 32'hFFF00413;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall in_ready", 64'(in_ready), 64'd0);
      chk("stall out_valid", 64'(out_valid), 64'd1);
      chk("stall out_pc", 64'(out_pc), 64'h300);
      chk("stall out_imm", 64'(out_imm), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    issue(32'h304, 32'hFFF00413, mk(32'h304, 0, 0, 32'hFFFFFFFF, 8, 1, 0, 0, 0, 0), "addi x8 -1");
    idle();
    chk("drain out_valid", 64'(out_valid), 64'd0);

    // redirect beats hazard, handshake and a taken beq
    issue(32'h500, 32'h00100313, mk(32'h500, 0, 0, 1, 6, 1, 0, 0, 0, 0), "addi pre-redirect");
    redirect = 1; ex_valid = 1; ex_memread = 1; ex_rd = 7;
    in_valid = 1; in_pc = 32'h504; in_inst = 32'h00738463;
    @(negedge clk);
    chk("redirect in_ready", 64'(in_ready), 64'd0);
    idle();
    chk("redirect out_valid", 64'(out_valid), 64'd0);
    chk("redirect br_taken", 64'(br_taken), 64'd0);
    chk("redirect stall_cnt", 64'(stall_cnt), 64'(STALL_TWO));
    redirect = 0; ex_valid = 0; ex_memread = 0; in_valid = 0;

    // reset while an output is held by backpressure
    out_ready = 0;
    issue(32'h600, 32'h00000713, mk(32'h600, 0, 0, 0, 14, 1, 0, 0, 0, 0), "addi held");
    in_valid = 1; in_pc = 32'h604;
    #3;
    rst = 1'b0;
    #1;
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset out_pc", 64'(out_pc), 64'd0);
    chk("async reset stall_cnt", 64'(stall_cnt), 64'd0);
    sb.delete();
    in_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1;
    in_valid = 1; in_pc = 32'h700; in_inst = 32'h003387B3;
    #1;
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    if (in_ready) sb.push_back(mk(32'h700, 0, 0, 0, 15, 1, 0, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 0;
    chk("post-reset out_valid", 64'(out_valid), 64'd1);
    idle();
    idle();
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
